// File: rtl/dmem_bridge_pkg.sv
// Shared types and lane helpers for the data-memory bridge: access sizes,
// bridge states, alignment check, byte-enable generation and lane steering.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Mode 2'b11 has no size, so it is always rejected along with unaligned halves/words.
  function automatic logic misaligned(input logic [1:0] mode, input logic [1:0] off);
    case (mode)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic size_e mode_to_size(input logic [1:0] mode);
    case (mode)
      2'b01:   mode_to_size = SZ_HALF;
      2'b10:   mode_to_size = SZ_WORD;
      default: mode_to_size = SZ_BYTE;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: byte_en = 4'b0001 << off;
      SZ_HALF: byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [31:0] d, input size_e sz);
    case (sz)
      SZ_BYTE: lane_replicate = {4{d[7:0]}};
      SZ_HALF: lane_replicate = {2{d[15:0]}};
      default: lane_replicate = d;
    endcase
  endfunction

  function automatic logic [31:0] lane_align(input logic [31:0] w, input size_e sz,
                                             input logic [1:0] off);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (sz)
      SZ_BYTE: lane_align = {24'h0, s[7:0]};
      SZ_HALF: lane_align = {16'h0, s[15:0]};
      default: lane_align = s;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Core dmem port plus external req/ack bus. The bridge uses the slave view;
// the core/bus environment uses the master view.
interface dmem_bridge_if;
  logic [31:0] dmem_address;
  logic        dmem_enable;
  logic [31:0] dmem_write_data;
  logic        dmem_write_enable;
  logic [2:0]  dmem_write_mode;
  logic        dmem_read_enable;
  logic [2:0]  dmem_read_mode;
  logic [31:0] dmem_read_data;
  logic        dmem_wait;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        fault;
  logic [31:0] fault_addr;

  modport slave (
    input  dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
           dmem_write_mode, dmem_read_enable, dmem_read_mode, bus_rdata, bus_ack,
    output dmem_read_data, dmem_wait, bus_req, bus_addr, bus_we, bus_be, bus_wdata,
           fault, fault_addr
  );

  modport master (
    output dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
           dmem_write_mode, dmem_read_enable, dmem_read_mode, bus_rdata, bus_ack,
    input  dmem_read_data, dmem_wait, bus_req, bus_addr, bus_we, bus_be, bus_wdata,
           fault, fault_addr
  );
endinterface

// File: rtl/dmem_sram.sv
// Byte-enabled synchronous single-port RAM, word organised, one-cycle read latency.
module dmem_sram #(
  parameter int RAM_BYTES = 16384,
  parameter int ADDR_W    = $clog2(RAM_BYTES / 4)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [RAM_BYTES / 4];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: decodes core requests, serves local SRAM in one cycle and
// forwards everything else to a req/ack bus with stall, alignment and timeout faults.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int RAM_BYTES      = 16384,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          reset_n,
  dmem_bridge_if.slave bus_if
);

  localparam int ADDR_W = $clog2(RAM_BYTES / 4);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state, state_nx;
  logic        stall, bus_active, ack_p0, timeout_p0;

  // Stage p0: request decode on the core's raw inputs
  logic        wr_p0, acc_p0, bad_p0, local_p0;
  logic        go_local_p0, go_ext_p0, go_bad_p0;
  logic [1:0]  mode_p0, off_p0;
  size_e       size_p0;
  logic [3:0]  sram_be;
  logic [31:0] wdata_p0;
  logic [31:0] sram_q;

  assign wr_p0    = bus_if.dmem_write_enable;
  assign mode_p0  = wr_p0 ? bus_if.dmem_write_mode[1:0] : bus_if.dmem_read_mode[1:0];
  assign off_p0   = bus_if.dmem_address[1:0];
  assign size_p0  = mode_to_size(mode_p0);
  assign acc_p0   = bus_if.dmem_enable && (state != ST_BUS)
                    && (wr_p0 || bus_if.dmem_read_enable);
  assign bad_p0   = misaligned(mode_p0, off_p0);
  assign local_p0 = bus_if.dmem_address < 32'(RAM_BYTES);

  assign go_bad_p0   = acc_p0 && bad_p0;
  assign go_local_p0 = acc_p0 && !bad_p0 && local_p0;
  assign go_ext_p0   = acc_p0 && !bad_p0 && !local_p0;
  assign sram_be     = byte_en(size_p0, off_p0);
  assign wdata_p0    = lane_replicate(bus_if.dmem_write_data, size_p0);

  dmem_sram #(.RAM_BYTES(RAM_BYTES), .ADDR_W(ADDR_W)) u_sram (
    .clk   (clk),
    .en    (go_local_p0),
    .we    (wr_p0),
    .be    (sram_be),
    .addr  (bus_if.dmem_address[ADDR_W+1:2]),
    .wdata (wdata_p0),
    .rdata (sram_q)
  );

  // Stage p1: latched bus transaction, local-load lane info, fault and read-data state
  logic [CNT_W-1:0] cnt_p1;
  logic [31:0]      addr_p1, wdata_p1, rdata_p1, fault_addr_p1;
  logic             we_p1, ld_local_p1, fault_p1;
  logic [3:0]       be_p1;
  size_e            size_p1, lsize_p1;
  logic [1:0]       off_p1, loff_p1;

  always_comb begin
    state_nx   = state;
    ack_p0     = 1'b0;
    timeout_p0 = 1'b0;
    stall      = 1'b0;
    bus_active = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: state_nx = go_ext_p0 ? ST_BUS : ST_IDLE;
      ST_BUS: begin
        stall      = 1'b1;
        bus_active = 1'b1;
        if (bus_if.bus_ack) begin
          state_nx = ST_DONE;
          ack_p0   = 1'b1;
        end else if (cnt_p1 == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nx   = ST_DONE;
          timeout_p0 = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cnt_p1        <= '0;
      addr_p1       <= '0;
      we_p1         <= 1'b0;
      be_p1         <= '0;
      wdata_p1      <= '0;
      size_p1       <= SZ_BYTE;
      off_p1        <= '0;
      ld_local_p1   <= 1'b0;
      lsize_p1      <= SZ_BYTE;
      loff_p1       <= '0;
      rdata_p1      <= '0;
      fault_p1      <= 1'b0;
      fault_addr_p1 <= '0;
    end else begin
      state       <= state_nx;
      ld_local_p1 <= go_local_p0 && !wr_p0;
      fault_p1    <= go_bad_p0 || timeout_p0;
      if (go_local_p0) begin
        lsize_p1 <= size_p0;
        loff_p1  <= off_p0;
      end
      if (go_ext_p0) begin
        cnt_p1   <= '0;
        addr_p1  <= bus_if.dmem_address;
        we_p1    <= wr_p0;
        be_p1    <= sram_be;
        wdata_p1 <= wdata_p0;
        size_p1  <= size_p0;
        off_p1   <= off_p0;
      end else if (state == ST_BUS) begin
        cnt_p1 <= cnt_p1 + 1'b1;
      end
      if (go_bad_p0)       fault_addr_p1 <= bus_if.dmem_address;
      else if (timeout_p0) fault_addr_p1 <= addr_p1;
      // A local load's SRAM word is presented combinationally for one cycle, then held here
      if (go_bad_p0 || timeout_p0)  rdata_p1 <= '0;
      else if (ack_p0 && !we_p1)    rdata_p1 <= lane_align(bus_if.bus_rdata, size_p1, off_p1);
      else if (ld_local_p1)         rdata_p1 <= lane_align(sram_q, lsize_p1, loff_p1);
    end
  end

  assign bus_if.dmem_read_data = ld_local_p1 ? lane_align(sram_q, lsize_p1, loff_p1) : rdata_p1;
  assign bus_if.dmem_wait      = stall;
  assign bus_if.bus_req        = bus_active;
  assign bus_if.bus_addr       = {addr_p1[31:2], 2'b00};
  assign bus_if.bus_we         = we_p1;
  assign bus_if.bus_be         = be_p1;
  assign bus_if.bus_wdata      = wdata_p1;
  assign bus_if.fault          = fault_p1;
  assign bus_if.fault_addr     = fault_addr_p1;

  // Bit 2 of the modes carries sign-extension intent for the core only
  logic unused_mode;
  assign unused_mode = bus_if.dmem_write_mode[2] ^ bus_if.dmem_read_mode[2];

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed and randomized bench for dmem_bridge against a byte-array memory model
// and an arithmetic bus-response model.
module tb_dmem_bridge;

  localparam int RAMB = 16384;
  localparam int TO   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  dmem_bridge_if bif();

  dmem_bridge #(.RAM_BYTES(RAMB), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_if  (bif)
  );

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  ref_mem [256];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic we, input logic re, input logic [2:0] wm,
                       input logic [2:0] rm, input logic [31:0] a, input logic [31:0] d);
    bif.dmem_enable       = en;
    bif.dmem_write_enable = we;
    bif.dmem_read_enable  = re;
    bif.dmem_write_mode   = wm;
    bif.dmem_read_mode    = rm;
    bif.dmem_address      = a;
    bif.dmem_write_data   = d;
  endtask

  task automatic idle_in();
    bif.dmem_enable       = 1'b0;
    bif.dmem_write_enable = 1'b0;
    bif.dmem_read_enable  = 1'b0;
  endtask

  task automatic op(input logic we, input logic [1:0] mode, input logic [31:0] a,
                    input logic [31:0] d);
    drive(1'b1, we, !we, {1'b0, mode}, {1'b0, mode}, a, d);
    step();
    idle_in();
  endtask

  // Plays the external target: acks in BUS cycle ack_at (0 = never); bounded cycle budget
  task automatic ext_serve(input int ack_at, input logic [31:0] rd, output int stall,
                           output logic stable);
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    a0 = bif.bus_addr; w0 = bif.bus_wdata; b0 = bif.bus_be; we0 = bif.bus_we;
    stall = 0;
    stable = 1'b1;
    while (bif.bus_req === 1'b1 && stall < 20) begin
      stall++;
      if (bif.bus_addr !== a0 || bif.bus_wdata !== w0 || bif.bus_be !== b0 ||
          bif.bus_we !== we0 || bif.dmem_wait !== 1'b1) stable = 1'b0;
      if (stall == ack_at) begin
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = rd;
      end
      step();
      bif.bus_ack   = 1'b0;
      bif.bus_rdata = $urandom;
    end
  endtask

  initial begin
    int          stall;
    logic        stable;
    logic [31:0] d;
    idle_in();
    bif.dmem_address = '0; bif.dmem_write_data = '0;
    bif.dmem_write_mode = '0; bif.dmem_read_mode = '0;
    bif.bus_ack = 1'b0; bif.bus_rdata = '0;
    #2 reset_n = 1'b0;
    #10;
    check("rst_rdata", bif.dmem_read_data, 32'h0);
    check1("rst_wait", bif.dmem_wait, 1'b0);
    check1("rst_req", bif.bus_req, 1'b0);
    check1("rst_we", bif.bus_we, 1'b0);
    check("rst_be", {28'h0, bif.bus_be}, 32'h0);
    check("rst_addr", bif.bus_addr, 32'h0);
    check("rst_wdata", bif.bus_wdata, 32'h0);
    check1("rst_fault", bif.fault, 1'b0);
    check("rst_faddr", bif.fault_addr, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Local word store and sub-word loads
    op(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
    check1("st_wait", bif.dmem_wait, 1'b0);
    check("st_rd_hold", bif.dmem_read_data, 32'h0);
    op(1'b0, 2'd0, 32'h101, 32'h0);
    check("ld_byte", bif.dmem_read_data, 32'h000000BE);
    check1("ld_byte_wait", bif.dmem_wait, 1'b0);
    op(1'b0, 2'd1, 32'h102, 32'h0);
    check("ld_half", bif.dmem_read_data, 32'h0000DEAD);
    op(1'b0, 2'd2, 32'h100, 32'h0);
    check("ld_word", bif.dmem_read_data, 32'hDEADBEEF);
    step();
    check("rd_hold_idle", bif.dmem_read_data, 32'hDEADBEEF);

    // Byte store into the top lane
    drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 32'h103, 32'h00000055);
    #1;
    check("sram_be", {28'h0, dut.sram_be}, 32'h8);
    step();
    idle_in();
    op(1'b0, 2'd2, 32'h100, 32'h0);
    check("ld_merge", bif.dmem_read_data, 32'h55ADBEEF);

    // External half load, ack in third BUS cycle
    op(1'b0, 2'd1, 32'h80000006, 32'h0);
    check1("ext_req", bif.bus_req, 1'b1);
    check1("ext_wait", bif.dmem_wait, 1'b1);
    check("ext_addr", bif.bus_addr, 32'h80000004);
    check("ext_be", {28'h0, bif.bus_be}, 32'hC);
    check1("ext_we", bif.bus_we, 1'b0);
    ext_serve(3, 32'h12345678, stall, stable);
    check("ext_stall", stall, 3);
    check1("ext_stable", stable, 1'b1);
    check1("ext_done_wait", bif.dmem_wait, 1'b0);
    check1("ext_done_req", bif.bus_req, 1'b0);
    check("ext_rdata", bif.dmem_read_data, 32'h00001234);
    step();

    // Misaligned word load
    op(1'b0, 2'd2, 32'h102, 32'h0);
    check1("mis_fault", bif.fault, 1'b1);
    check("mis_faddr", bif.fault_addr, 32'h102);
    check("mis_rdata", bif.dmem_read_data, 32'h0);
    check1("mis_req", bif.bus_req, 1'b0);
    check1("mis_wait", bif.dmem_wait, 1'b0);
    step();
    check1("mis_pulse", bif.fault, 1'b0);

    // External byte store that never gets acked
    op(1'b1, 2'd0, 32'h90000001, 32'h000000A5);
    check("to_be", {28'h0, bif.bus_be}, 32'h2);
    check("to_wdata", bif.bus_wdata, 32'hA5A5A5A5);
    check1("to_we", bif.bus_we, 1'b1);
    check("to_addr", bif.bus_addr, 32'h90000000);
    ext_serve(0, 32'h0, stall, stable);
    check("to_stall", stall, TO);
    check1("to_stable", stable, 1'b1);
    check1("to_req", bif.bus_req, 1'b0);
    check1("to_wait", bif.dmem_wait, 1'b0);
    check1("to_fault", bif.fault, 1'b1);
    check("to_faddr", bif.fault_addr, 32'h90000001);
    check("to_rdata", bif.dmem_read_data, 32'h0);
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'hFFFFFFFF;
    step();
    step();
    bif.bus_ack = 1'b0;
    check1("spur_req", bif.bus_req, 1'b0);
    check1("spur_fault", bif.fault, 1'b0);
    check("spur_rdata", bif.dmem_read_data, 32'h0);

    // Reset in the middle of a bus transaction
    op(1'b0, 2'd2, 32'h80000010, 32'h0);
    check1("mid_req", bif.bus_req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check1("arst_req", bif.bus_req, 1'b0);
    check1("arst_wait", bif.dmem_wait, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    op(1'b1, 2'd2, 32'h200, 32'h0BADF00D);
    op(1'b0, 2'd2, 32'h200, 32'h0);
    check("post_rst_word", bif.dmem_read_data, 32'h0BADF00D);
    op(1'b0, 2'd0, 32'h203, 32'h0);
    check("post_rst_byte", bif.dmem_read_data, 32'h0000000B);
    last_rd = 32'h0000000B;

    // Randomized traffic against the reference model
    for (int w = 0; w < 64; w++) begin
      d = $urandom;
      op(1'b1, 2'd2, 32'(w * 4), d);
      for (int i = 0; i < 4; i++) ref_mem[w*4 + i] = d[8*i +: 8];
    end
    for (int n = 0; n < 120; n++) begin
      int          kind, nb, ack_at, off;
      logic        wr, re, bad, rb;
      logic [1:0]  mode;
      logic [31:0] a, dv, rdv, ex, mask;
      kind = $urandom_range(0, 9);
      wr   = 1'($urandom_range(0, 1));
      re   = 1'($urandom_range(0, 1));
      rb   = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      a    = (kind >= 7 && kind <= 8) ? {1'b1, 31'($urandom)} : 32'($urandom_range(0, 255));
      dv   = $urandom;
      off  = int'(a[1:0]);
      nb   = 1 << mode;
      bad  = (mode == 2'd3) || (mode == 2'd1 && a[0]) || (mode == 2'd2 && a[1:0] != 2'd0);
      mask = (nb == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * nb)) - 32'h1);
      if (kind == 9) begin
        drive(1'b1, 1'b0, 1'b0, 3'($urandom), 3'($urandom), a, dv);
        step();
        idle_in();
        check("rnd_noacc_rd", bif.dmem_read_data, last_rd);
        check1("rnd_noacc_req", bif.bus_req, 1'b0);
      end else begin
        if (wr) drive(1'b1, 1'b1, re, {1'b0, mode}, 3'($urandom), a, dv);
        else    drive(1'b1, 1'b0, 1'b1, 3'($urandom), {rb, mode}, a, dv);
        step();
        idle_in();
        if (bad) begin
          check1("rnd_mis_fault", bif.fault, 1'b1);
          check("rnd_mis_faddr", bif.fault_addr, a);
          check("rnd_mis_rd", bif.dmem_read_data, 32'h0);
          check1("rnd_mis_req", bif.bus_req, 1'b0);
          last_rd = 32'h0;
        end else if (a < 32'd256) begin
          if (wr) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = dv[8*i +: 8];
            check("rnd_st_hold", bif.dmem_read_data, last_rd);
          end else begin
            ex = 32'h0;
            for (int i = 0; i < nb; i++) ex = ex | (32'(ref_mem[int'(a) + i]) << (8 * i));
            check("rnd_ld", bif.dmem_read_data, ex);
            last_rd = ex;
          end
          check1("rnd_loc_wait", bif.dmem_wait, 1'b0);
          check1("rnd_loc_fault", bif.fault, 1'b0);
        end else begin
          check("rnd_ext_addr", bif.bus_addr, {a[31:2], 2'b00});
          check("rnd_ext_be", {28'h0, bif.bus_be}, ((32'h1 << nb) - 32'h1) << off);
          check1("rnd_ext_we", bif.bus_we, wr);
          if (wr) check("rnd_ext_wd", bif.bus_wdata,
                        (nb == 1) ? {4{dv[7:0]}} : (nb == 2) ? {2{dv[15:0]}} : dv);
          ack_at = $urandom_range(1, 3);
          rdv = $urandom;
          ext_serve(ack_at, rdv, stall, stable);
          check("rnd_ext_stall", stall, ack_at);
          check1("rnd_ext_stable", stable, 1'b1);
          check1("rnd_ext_fault", bif.fault, 1'b0);
          if (!wr) begin
            ex = (rdv >> (8 * off)) & mask;
            last_rd = ex;
          end
          check("rnd_ext_rd", bif.dmem_read_data, last_rd);
        end
        if ($urandom_range(0, 1) == 1) step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory side of the core: terminates the core's dmem request port (inputs registered here, read data valid one cycle later).
- Routes each access to either a local byte-addressable synchronous SRAM (fixed 1-cycle latency) or an external req/ack bus (variable latency, stalls the core via dmem_wait).
- Performs byte-lane steering, right-aligns read data, enforces natural alignment and bus timeout.

Parameters:
- RAM_BYTES, 16384, local SRAM size; addresses below this are local, all others external.
- TIMEOUT_CYCLES, 255, max cycles waiting for bus_ack before aborting.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- dmem_address  in  32  byte address
- dmem_enable  in  1  request strobe; sampled at rising edge
- dmem_write_data  in  32  store data, right-aligned
- dmem_write_enable  in  1  store
- dmem_write_mode  in  3  000 byte, 001 half, 010 word
- dmem_read_enable  in  1  load
- dmem_read_mode  in  3  low 2 bits give size as for write_mode; bit 2 ignored here (core extends)
- dmem_read_data  out  32  load data, right-aligned, upper bits zero
- dmem_wait  out  1  core must hold pipeline
- bus_req  out  1  external request valid
- bus_addr  out  32  word-aligned address
- bus_we  out  1  write
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-steered write data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  completion
- fault  out  1  one-cycle pulse: misaligned access or timeout
- fault_addr  out  32  address of last faulting access

Behaviour:
- Reset (async, active-low): state IDLE; dmem_read_data=0, dmem_wait=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, fault=0, fault_addr=0; SRAM contents undefined.
- Request accepted at edge E when dmem_enable=1 and state in {IDLE, DONE}, and (read_enable or write_enable). Neither set: no access, read_data holds. Both set: write takes precedence.
- Byte enables: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111. Write data replicated across lanes (byte x4, half x2).
- Misaligned (half with a[0]=1, word with a[1:0]!=0, or mode 011/111): no access; fault=1 cycle after E; fault_addr=address; read_data=0; no stall.
- Local: SRAM write/read at E; cycle after E read_data = selected lanes shifted to bit 0, zero-filled; dmem_wait=0. Store leaves read_data unchanged.
- External FSM: IDLE -> BUS (at E, latch addr/we/be/wdata/size/offset; bus_req=1, wait=1). BUS: req and all bus outputs held stable until bus_ack. Ack in cycle A -> DONE at A+1: capture rdata, shift to bit 0 on loads; wait=0, req=0. DONE behaves as IDLE (accepts new request) and returns to IDLE if none. Ack in first BUS cycle permitted (1-cycle stall minimum).
- Timeout: counter clears on entering BUS, increments each BUS cycle; reaching TIMEOUT_CYCLES without ack -> DONE with read_data=0, fault pulse, fault_addr latched, bus_req dropped. Late ack outside BUS ignored.
- bus_ack while bus_req=0: ignored.
- dmem_wait derived combinationally from state (BUS only); never depends on dmem_enable.
- dmem_enable during BUS ignored (core is stalled).
- Reset during BUS: FSM to IDLE immediately, bus_req drops asynchronously; transaction abandoned.
- Address wrap: no special case; 0xFFFFFFFC word is external.

Decomposition:
- Shared package: access-size enum (BYTE/HALF/WORD), bridge state enum (IDLE/BUS/DONE), helper function for byte-enable generation and lane alignment.
- Sub-module: dmem_sram (byte-enabled synchronous single-port RAM, RAM_BYTES deep, 1-cycle read latency); bridge instantiates one.

Test Plan:
- Local word store 0xDEADBEEF @0x100, then loads: byte @0x101 -> read_data 0x000000BE next cycle, half @0x102 -> 0x0000DEAD, word -> 0xDEADBEEF; wait stays 0 throughout.
- Byte store 0x55 @0x103 over previous word, word load @0x100 -> 0x55ADBEEF (be=1000 verified on SRAM).
- External load @0x80000006 half, bus_ack after 3 cycles with bus_rdata=0x12345678 -> bus_be=1100, bus_addr=0x80000004, wait high 3 cycles, next cycle read_data=0x00001234.
- Misaligned word load @0x102 -> fault pulse 1 cycle, fault_addr=0x102, read_data=0, no bus_req, wait=0.
- External store with no ack, TIMEOUT_CYCLES=4 -> bus_req high 4 cycles then drops, fault pulse, wait deasserts; later spurious ack ignored.
- Assert reset_n=0 mid-BUS -> bus_req and wait fall without clock edge; after release, local load works normally.
